// File: rtl/conn4_pkg.sv
// Shared types and constants for the connect-four piece drop controller.
// Board geometry, key codes and the controller state encoding live here.
package conn4_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FALL,
        LAND,
        DONE
    } state_t;

    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 6;

    localparam logic [9:0] SLOT_X0    = 10'd75;
    localparam logic [9:0] SLOT_Y0    = 10'd325;
    localparam logic [9:0] SLOT_PITCH = 10'd50;
    localparam logic [9:0] HOVER_Y    = 10'd25;
    localparam logic [9:0] FALL_STEP  = 10'd5;

    localparam logic [5:0] NUM_SLOTS = 6'd42;

    localparam logic [7:0] KEY_LEFT  = 8'h50;
    localparam logic [7:0] KEY_RIGHT = 8'h4F;
    localparam logic [7:0] KEY_DROP  = 8'h28;

    function automatic logic [9:0] slot_x(input logic [2:0] c);
        return SLOT_X0 + SLOT_PITCH * {7'd0, c};
    endfunction

    function automatic logic [9:0] slot_y(input logic [2:0] r);
        return SLOT_Y0 - SLOT_PITCH * {7'd0, r};
    endfunction

endpackage

// File: rtl/rise_det.sv
// Single-bit rising-edge detector in the clk domain.
// rise is high for the one cycle where d is high and was low last cycle.
module rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

    assign rise = d & ~q;

endmodule

// File: rtl/drop_ctrl.sv
// Connect-four piece controller: cursor movement, animated fall,
// landing bookkeeping and end-of-game detection.
module drop_ctrl
    import conn4_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    output logic [9:0] PieceX,
    output logic [9:0] PieceY,
    output logic       player,
    output logic       place_valid,
    output logic [2:0] place_col,
    output logic [2:0] place_row,
    output logic       game_over
);

    state_t state, state_d;

    logic [7:0] kc_q;
    logic       tick;
    logic       press;

    logic [2:0] col, col_d;
    logic [2:0] row, row_d;
    logic [5:0] cnt, cnt_d;
    logic [9:0] px_d, py_d;
    logic       player_d;
    logic       pv_d;
    logic [2:0] pcol_d, prow_d;
    logic       go_d;

    logic [NUM_COLS-1:0][2:0] height, height_d;

    logic [9:0] y_next;
    logic [9:0] tgt;

    rise_det u_tick (
        .clk  (Clk),
        .rst_n(Reset),
        .d    (frame_clk),
        .rise (tick)
    );

    assign press  = (keycode != kc_q) && (keycode != 8'h00);
    assign y_next = PieceY + FALL_STEP;
    assign tgt    = slot_y(row);

    always_comb begin
        state_d  = state;
        col_d    = col;
        row_d    = row;
        cnt_d    = cnt;
        height_d = height;
        px_d     = PieceX;
        py_d     = PieceY;
        player_d = player;
        pv_d     = 1'b0;
        pcol_d   = place_col;
        prow_d   = place_row;
        go_d     = game_over;

        unique case (state)
            IDLE: begin
                if (press) begin
                    if (keycode == KEY_LEFT) begin
                        if (col != 3'd0) col_d = col - 3'd1;
                    end else if (keycode == KEY_RIGHT) begin
                        if (col != 3'(NUM_COLS - 1)) col_d = col + 3'd1;
                    end else if (keycode == KEY_DROP) begin
                        if (height[col] < 3'(NUM_ROWS)) begin
                            row_d   = height[col];
                            state_d = FALL;
                        end
                    end
                end
                px_d = slot_x(col_d);
            end
            FALL: begin
                // Clamp onto the slot so the sprite never overshoots.
                if (tick) begin
                    if (y_next >= tgt) begin
                        py_d    = tgt;
                        state_d = LAND;
                        pv_d    = 1'b1;
                        pcol_d  = col;
                        prow_d  = row;
                    end else begin
                        py_d = y_next;
                    end
                end
            end
            LAND: begin
                height_d[col] = height[col] + 3'd1;
                cnt_d         = cnt + 6'd1;
                player_d      = ~player;
                if (cnt_d == NUM_SLOTS) begin
                    state_d = DONE;
                    go_d    = 1'b1;
                end else begin
                    state_d = IDLE;
                    py_d    = HOVER_Y;
                end
            end
            DONE: begin
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state       <= IDLE;
            kc_q        <= 8'h00;
            col         <= 3'd3;
            row         <= 3'd0;
            cnt         <= 6'd0;
            height      <= '0;
            PieceX      <= slot_x(3'd3);
            PieceY      <= HOVER_Y;
            player      <= 1'b0;
            place_valid <= 1'b0;
            place_col   <= 3'd0;
            place_row   <= 3'd0;
            game_over   <= 1'b0;
        end else begin
            state       <= state_d;
            kc_q        <= keycode;
            col         <= col_d;
            row         <= row_d;
            cnt         <= cnt_d;
            height      <= height_d;
            PieceX      <= px_d;
            PieceY      <= py_d;
            player      <= player_d;
            place_valid <= pv_d;
            place_col   <= pcol_d;
            place_row   <= prow_d;
            game_over   <= go_d;
        end
    end

endmodule

// File: tb/tb_drop_ctrl.sv
// Directed plus randomized bench for drop_ctrl against a board-level model
// (cursor column, column heights, turn and piece count).
module tb_drop_ctrl;

    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       frame_clk = 1'b0;
    logic [7:0] keycode = 8'h00;
    logic [9:0] PieceX, PieceY;
    logic       player, place_valid, game_over;
    logic [2:0] place_col, place_row;

    int checks = 0;
    int errors = 0;

    int m_col;
    int m_player;
    int m_count;
    int m_h[7];

    drop_ctrl dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .keycode    (keycode),
        .PieceX     (PieceX),
        .PieceY     (PieceY),
        .player     (player),
        .place_valid(place_valid),
        .place_col  (place_col),
        .place_row  (place_row),
        .game_over  (game_over)
    );

    always #5 Clk = ~Clk;

    initial begin
        #5ms;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    function automatic int xpos(input int c);
        return 75 + 50 * c;
    endfunction

    function automatic int ypos(input int r);
        return 325 - 50 * r;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic model_reset();
        m_col = 3;
        m_player = 0;
        m_count = 0;
        for (int i = 0; i < 7; i++) m_h[i] = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        keycode = 8'h00;
        frame_clk = 1'b0;
        step();
        step();
        Reset = 1'b1;
        model_reset();
        step();
    endtask

    task automatic tick();
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        step();
    endtask

    task automatic press(input logic [7:0] k);
        keycode = k;
        step();
        if (k == 8'h50 && m_col > 0) m_col--;
        if (k == 8'h4F && m_col < 6) m_col++;
        keycode = 8'h00;
        step();
    endtask

    task automatic move_to(input int c);
        for (int i = 0; i < 7; i++) begin
            if (m_col > c) press(8'h50);
            else if (m_col < c) press(8'h4F);
        end
        chk("move_x", PieceX, xpos(c));
    endtask

    task automatic drop(input bit inject);
        int r, tgt, n;
        r = m_h[m_col];
        tgt = ypos(r);
        n = (tgt - 25) / 5;
        keycode = 8'h28;
        step();
        keycode = 8'h00;
        step();
        for (int i = 1; i <= n; i++) begin
            frame_clk = 1'b1;
            if (inject && (i == 3)) keycode = 8'h4F;
            step();
            frame_clk = 1'b0;
            keycode = 8'h00;
            if (i < n) begin
                if ((i % 10) == 0) chk("fall_y", PieceY, 25 + 5 * i);
                if (place_valid !== 1'b0) chk("early_pv", place_valid, 0);
            end else begin
                chk("land_y", PieceY, tgt);
                chk("land_pv", place_valid, 1);
                chk("land_col", place_col, m_col);
                chk("land_row", place_row, r);
            end
            step();
        end
        m_h[m_col]++;
        m_count++;
        m_player ^= 1;
        chk("pv_pulse", place_valid, 0);
        chk("player", player, m_player);
        chk("after_x", PieceX, xpos(m_col));
        if (m_count == 42) begin
            chk("done_y", PieceY, tgt);
            chk("done_go", game_over, 1);
        end else begin
            chk("hover_y", PieceY, 25);
            chk("not_over", game_over, 0);
        end
    endtask

    task automatic full_press();
        keycode = 8'h28;
        step();
        keycode = 8'h00;
        chk("full_pv", place_valid, 0);
        step();
        tick();
        chk("full_y", PieceY, 25);
        chk("full_pv2", place_valid, 0);
    endtask

    initial begin
        int c, guard, hold_y, hold_x;
        model_reset();

        Reset = 1'b0;
        #13;
        chk("rst_x", PieceX, 225);
        chk("rst_y", PieceY, 25);
        chk("rst_player", player, 0);
        chk("rst_pv", place_valid, 0);
        chk("rst_pcol", place_col, 0);
        chk("rst_prow", place_row, 0);
        chk("rst_go", game_over, 0);
        do_reset();

        // held key produces a single step
        keycode = 8'h4F;
        for (int i = 0; i < 3; i++) tick();
        keycode = 8'h00;
        step();
        chk("hold_x", PieceX, 275);

        // drop into empty centre column
        do_reset();
        drop(1'b0);
        chk("first_row_h", m_h[3], 1);

        // saturate left, then a right press during the fall is ignored
        do_reset();
        for (int i = 0; i < 5; i++) press(8'h50);
        chk("sat_left_x", PieceX, 75);
        drop(1'b1);
        for (int i = 0; i < 9; i++) press(8'h4F);
        chk("sat_right_x", PieceX, 375);

        // fill column 0 then a drop there is refused
        do_reset();
        move_to(0);
        for (int i = 0; i < 6; i++) drop(1'b0);
        full_press();

        // reset in the middle of a fall
        do_reset();
        keycode = 8'h28;
        step();
        keycode = 8'h00;
        step();
        for (int i = 0; i < 25; i++) tick();
        chk("mid_y", PieceY, 150);
        Reset = 1'b0;
        #2;
        chk("abort_y", PieceY, 25);
        chk("abort_x", PieceX, 225);
        chk("abort_pv", place_valid, 0);
        step();
        Reset = 1'b1;
        model_reset();
        step();
        drop(1'b0);

        // random full game
        do_reset();
        guard = 0;
        while (m_count < 42 && guard < 600) begin
            guard++;
            c = $urandom_range(0, 6);
            move_to(c);
            if (m_h[c] == 6) full_press();
            else drop(1'($urandom_range(0, 1)));
        end
        chk("fill_count", m_count, 42);
        hold_y = PieceY;
        hold_x = PieceX;
        keycode = 8'h28;
        step();
        keycode = 8'h00;
        step();
        tick();
        press(8'h50);
        chk("over_y", PieceY, hold_y);
        chk("over_x", PieceX, hold_x);
        chk("over_pv", place_valid, 0);
        chk("over_go", game_over, 1);
        chk("over_player", player, m_player);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
